s2mm_burst_ctrl: RTL and testbench
==================================

// Module: s2mm_burst_ctrl
// PURPOSE
//  Parametrised traffic source/controller for the AXI DataMover S2MM channel.
//  - Issues one S2MM command per burst.
//  - Streams a decrementing test pattern with tlast at each burst end.
//  - Walks a ring of NUM_BURSTS buffers starting at BASE_ADDR and collects status.
//  - Sits beside the block-design wrapper; drives its CMD/stream ports and consumes STS.
// PARAMETERS
//  DATA_W      32       stream width in bits; multiple of 32, 32..256
//  ADDR_W      32       DataMover address width; command width CMD_W = ADDR_W+40
//  BURST_BEATS 256      beats per burst; BTT = BURST_BEATS*DATA_W/8, must be < 2**23
//  NUM_BURSTS  64       bursts per ring before the address wraps; >= 1
//  BASE_ADDR   'h0      ring start byte address; aligned to DATA_W/8
// PORTS
//  clk               in   1        single clock; all logic synchronous to it
//  reset_n           in   1        asynchronous active-low reset
//  start             in   1        1-cycle pulse: begin continuous run (ignored while busy)
//  stop              in   1        1-cycle pulse: finish current burst, then idle
//  busy              out  1        high from start accept until the final burst's last beat completes
//  m_axis_cmd_tdata  out  CMD_W    S2MM command
//  m_axis_cmd_tvalid out  1        command valid
//  m_axis_cmd_tready in   1        command ready
//  m_axis_tdata      out  DATA_W   pattern data
//  m_axis_tkeep      out  DATA_W/8 all ones
//  m_axis_tlast      out  1        high on the last beat of each burst
//  m_axis_tvalid     out  1        data valid
//  m_axis_tready     in   1        data ready
//  s_axis_sts_tdata  in   8        status {OKAY,SLVERR,DECERR,INTERR,tag[3:0]}
//  s_axis_sts_tvalid in   1        status valid
//  s_axis_sts_tready out  1        tied 1 after reset
//  burst_count       out  32       bursts completed (last-beat handshakes); wraps mod 2**32
//  sts_count         out  32       status words accepted
//  last_sts          out  8        last accepted status byte
//  err_count         out  16       status errors; saturates at 16'hFFFF
// BEHAVIOUR
//  Reset (async, reset_n=0):
//   - All outputs 0.
//   - Pattern register = all ones; address = BASE_ADDR; tag = 0; state IDLE.
//   - Mid-operation reset aborts immediately; there is no drain.
//  cmd_tdata = {4'h0, tag[3:0], addr[ADDR_W-1:0], 8'h40 (EOF=1, DSA=0, DRR=0), 1'b1 (INCR), BTT[22:0]}.
//  FSM states:
//   IDLE: start=1 -> CMD; cmd_tvalid rises the next cycle.
//         start and stop in the same cycle -> exactly one burst, then IDLE.
//   CMD:  cmd_tvalid held and cmd_tdata stable until tready.
//         On handshake -> DATA; m_axis_tvalid rises the next cycle.
//   DATA: tvalid held; tdata/tlast stable while tready=0.
//         On each beat handshake, pattern decrements by 1 (DATA_W-bit, wraps at 0).
//         On the last-beat handshake:
//          - burst_count+1; tag+1 (mod 16).
//          - addr += BTT; after NUM_BURSTS bursts, addr = BASE_ADDR.
//          - If stop is pending -> IDLE, with busy=0 the next cycle; else -> CMD with no bubble cycle.
//  stop: latched in CMD/DATA and honoured only at the burst boundary.
//   - A burst in progress always completes; AXI valids never drop without a handshake.
//  Beat counter: counts 0..BURST_BEATS-1; tlast = (count == BURST_BEATS-1). BURST_BEATS=1 -> tlast every beat.
//  Status: every s_axis_sts_tvalid cycle is accepted; sts_count+1 and last_sts updated.
//   - A status word arriving in the same cycle as a last-beat handshake is handled independently.
// CONFIGURATION
//  S2MM_STS_CHECK_EN defined:
//   - An expected-tag counter (reset 0, +1 per status) is checked against sts[3:0].
//   - err_count+1 on any of: OKAY=0, SLVERR, DECERR, INTERR, or tag mismatch; one increment per word.
//  S2MM_STS_CHECK_EN undefined:
//   - No expected-tag logic; err_count tied 0; sts_count/last_sts unchanged.
// TESTING
//  1 DATA_W=32, BURST_BEATS=4; start, all readys 1 -> cmd_tdata=72'h00_00000000_40800010.
//    Then data FFFFFFFF, FFFFFFFE, FFFFFFFD, FFFFFFFC with tlast on beat 4 only.
//  2 NUM_BURSTS=2, BURST_BEATS=4 -> command addrs 0x0, 0x10, 0x0 with tags 0, 1, 2.
//    burst_count=3 after three bursts.
//  3 m_axis_tready toggled pseudo-randomly -> no beat lost or duplicated; tdata stable while stalled.
//    cmd_tready held 0 for 10 cycles -> cmd_tvalid stays 1 with constant tdata.
//  4 stop pulsed on beat 2 of burst 0 -> burst completes with tlast.
//    busy falls 1 cycle after the last beat; burst_count=1; no further command.
//  5 Macro on: sts 8'h80 (tag 0) -> err_count 0; then sts 8'h85 (expected tag 1) -> err_count 1.
//    sts 8'h02 -> err_count 2. Macro off: same stimulus -> err_count 0, sts_count 3, last_sts 8'h02.
//  6 reset_n low mid-DATA, asynchronous to clk -> all outputs 0 before the next edge.
//    After release and a start pulse -> addr BASE_ADDR, tag 0, pattern restarts at all ones.

Source files
------------

// File: rtl/s2mm_burst_ctrl.sv
// Traffic source/controller for the AXI DataMover S2MM channel: one command per burst,
// decrementing data pattern, ring of buffers, status collection (S2MM_STS_CHECK_EN adds tag/error checks).
module s2mm_burst_ctrl #(
   parameter int                DATA_W      = 32,
   parameter int                ADDR_W      = 32,
   parameter int                BURST_BEATS = 256,
   parameter int                NUM_BURSTS  = 64,
   parameter logic [ADDR_W-1:0] BASE_ADDR   = '0
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic                  stop,
   output logic                  busy,
   output logic [ADDR_W+39:0]    m_axis_cmd_tdata,
   output logic                  m_axis_cmd_tvalid,
   input  logic                  m_axis_cmd_tready,
   output logic [DATA_W-1:0]     m_axis_tdata,
   output logic [DATA_W/8-1:0]   m_axis_tkeep,
   output logic                  m_axis_tlast,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   input  logic [7:0]            s_axis_sts_tdata,
   input  logic                  s_axis_sts_tvalid,
   output logic                  s_axis_sts_tready,
   output logic [31:0]           burst_count,
   output logic [31:0]           sts_count,
   output logic [7:0]            last_sts,
   output logic [15:0]           err_count
);

   localparam int KEEP_W = DATA_W / 8;
   localparam int CNT_W  = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;
   localparam int RING_W = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;

   localparam logic [22:0]       BTT       = 23'(BURST_BEATS * KEEP_W);
   localparam logic [ADDR_W-1:0] BTT_ADDR  = ADDR_W'(BURST_BEATS * KEEP_W);
   localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BURST_BEATS - 1);
   localparam logic [RING_W-1:0] LAST_BUF  = RING_W'(NUM_BURSTS - 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CMD  = 2'd1;
   localparam logic [1:0] ST_DATA = 2'd2;

   logic [1:0]        state;
   logic              stop_pend;
   logic [CNT_W-1:0]  beat_cnt;
   logic [DATA_W-1:0] pattern;
   logic [ADDR_W-1:0] addr;
   logic [3:0]        tag;
   logic [RING_W-1:0] ring_idx;
   logic              out_en;

   logic cmd_hs;
   logic beat_hs;
   logic last_beat;
   logic last_hs;
   logic sts_hs;

   assign cmd_hs    = m_axis_cmd_tvalid & m_axis_cmd_tready;
   assign beat_hs   = m_axis_tvalid & m_axis_tready;
   assign last_beat = (beat_cnt == LAST_BEAT);
   assign last_hs   = beat_hs & last_beat;
   assign sts_hs    = s_axis_sts_tvalid & s_axis_sts_tready;

   // Payload outputs are gated by their valids so every output reads 0 while in reset.
   assign busy              = (state != ST_IDLE);
   assign m_axis_cmd_tvalid = (state == ST_CMD);
   assign m_axis_tvalid     = (state == ST_DATA);
   assign m_axis_cmd_tdata  = m_axis_cmd_tvalid ? {4'h0, tag, addr, 8'h40, 1'b1, BTT} : '0;
   assign m_axis_tdata      = m_axis_tvalid ? pattern : '0;
   assign m_axis_tlast      = m_axis_tvalid & last_beat;
   assign m_axis_tkeep      = {KEEP_W{out_en}};
   assign s_axis_sts_tready = out_en;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= ST_IDLE;
         stop_pend <= 1'b0;
         out_en    <= 1'b0;
      end else begin
         out_en <= 1'b1;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state     <= ST_CMD;
                  stop_pend <= stop;
               end
            end
            ST_CMD: begin
               if (stop)   stop_pend <= 1'b1;
               if (cmd_hs) state     <= ST_DATA;
            end
            ST_DATA: begin
               if (stop) stop_pend <= 1'b1;
               if (last_hs) begin
                  if (stop_pend || stop) begin
                     state     <= ST_IDLE;
                     stop_pend <= 1'b0;
                  end else begin
                     state <= ST_CMD;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         beat_cnt <= '0;
         pattern  <= '1;
      end else if (beat_hs) begin
         beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
         pattern  <= pattern - 1'b1;
      end
   end

   // Ring walk: the buffer after the last one returns to BASE_ADDR.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         addr        <= BASE_ADDR;
         tag         <= 4'h0;
         ring_idx    <= '0;
         burst_count <= '0;
      end else if (last_hs) begin
         tag         <= tag + 4'h1;
         burst_count <= burst_count + 32'd1;
         if (ring_idx == LAST_BUF) begin
            ring_idx <= '0;
            addr     <= BASE_ADDR;
         end else begin
            ring_idx <= ring_idx + 1'b1;
            addr     <= addr + BTT_ADDR;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sts_count <= '0;
         last_sts  <= '0;
      end else if (sts_hs) begin
         sts_count <= sts_count + 32'd1;
         last_sts  <= s_axis_sts_tdata;
      end
   end

`ifdef S2MM_STS_CHECK_EN
   logic [3:0] exp_tag;
   logic       sts_err;

   // Any bad status flag or tag mismatch counts once per word.
   assign sts_err = ~s_axis_sts_tdata[7] | s_axis_sts_tdata[6] | s_axis_sts_tdata[5] |
                    s_axis_sts_tdata[4] | (s_axis_sts_tdata[3:0] != exp_tag);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         exp_tag   <= 4'h0;
         err_count <= '0;
      end else if (sts_hs) begin
         exp_tag <= exp_tag + 4'h1;
         if (sts_err && (err_count != 16'hFFFF)) err_count <= err_count + 16'd1;
      end
   end
`else
   assign err_count = '0;
`endif

endmodule

// File: tb/tb_s2mm_burst_ctrl.sv
// Self-checking bench for s2mm_burst_ctrl: scoreboard of expected commands/beats, directed steps
// covering ring wrap, stalls, stop handling, status counting and asynchronous reset.
module tb_s2mm_burst_ctrl;

   localparam int          DATA_W = 32;
   localparam int          ADDR_W = 32;
   localparam int          BEATS  = 4;
   localparam int          NB     = 2;
   localparam logic [31:0] BASE   = 32'h0;
   localparam int          CMD_W  = ADDR_W + 40;
   localparam int          BTT_B  = BEATS * DATA_W / 8;
   localparam int          BUDGET = 400;

   logic              clk;
   logic              reset_n;
   logic              start;
   logic              stop;
   logic              busy;
   logic [CMD_W-1:0]  m_axis_cmd_tdata;
   logic              m_axis_cmd_tvalid;
   logic              m_axis_cmd_tready;
   logic [DATA_W-1:0] m_axis_tdata;
   logic [3:0]        m_axis_tkeep;
   logic              m_axis_tlast;
   logic              m_axis_tvalid;
   logic              m_axis_tready;
   logic [7:0]        s_axis_sts_tdata;
   logic              s_axis_sts_tvalid;
   logic              s_axis_sts_tready;
   logic [31:0]       burst_count;
   logic [31:0]       sts_count;
   logic [7:0]        last_sts;
   logic [15:0]       err_count;

   s2mm_burst_ctrl #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BURST_BEATS(BEATS), .NUM_BURSTS(NB), .BASE_ADDR(BASE)
   ) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .busy(busy),
      .m_axis_cmd_tdata(m_axis_cmd_tdata), .m_axis_cmd_tvalid(m_axis_cmd_tvalid),
      .m_axis_cmd_tready(m_axis_cmd_tready),
      .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
      .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
      .s_axis_sts_tdata(s_axis_sts_tdata), .s_axis_sts_tvalid(s_axis_sts_tvalid),
      .s_axis_sts_tready(s_axis_sts_tready),
      .burst_count(burst_count), .sts_count(sts_count), .last_sts(last_sts), .err_count(err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   logic [CMD_W-1:0]  cmd_q[$];
   logic [DATA_W:0]   beat_q[$];

   logic [31:0] m_addr   = BASE;
   logic [3:0]  m_tag    = 4'h0;
   logic [31:0] m_pat    = '1;
   int          m_ring   = 0;
   logic [31:0] m_bursts = 0;

   logic             rand_rdy = 1'b0;
   logic             cmd_stall = 1'b0;
   logic             dat_stall = 1'b0;
   logic [CMD_W-1:0] cmd_prev;
   logic [DATA_W:0]  dat_prev;

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model of one burst: command word, beats, then ring/tag/pattern advance.
   task automatic expect_burst();
      cmd_q.push_back({4'h0, m_tag, m_addr, 8'h40, 1'b1, 23'(BTT_B)});
      for (int i = 0; i < BEATS; i++) begin
         beat_q.push_back({(i == BEATS - 1), m_pat});
         m_pat = m_pat - 32'd1;
      end
      m_tag    = m_tag + 4'h1;
      m_bursts = m_bursts + 32'd1;
      if (m_ring == NB - 1) begin
         m_ring = 0;
         m_addr = BASE;
      end else begin
         m_ring = m_ring + 1;
         m_addr = m_addr + 32'(BTT_B);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check(tag, 256'({busy, m_axis_cmd_tvalid, m_axis_cmd_tdata, m_axis_tdata, m_axis_tkeep,
                       m_axis_tlast, m_axis_tvalid, s_axis_sts_tready, burst_count, sts_count,
                       last_sts, err_count}), 256'd0);
   endtask

   task automatic pulse_start(input logic with_stop);
      start = 1'b1;
      stop  = with_stop;
      tick();
      start = 1'b0;
      stop  = 1'b0;
   endtask

   task automatic pulse_stop();
      stop = 1'b1;
      tick();
      stop = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (busy && n < BUDGET) begin
         tick();
         n++;
      end
      check(tag, 256'(n < BUDGET), 256'd1);
   endtask

   // Output monitor: handshakes seen at negedge complete on the following posedge.
   always @(negedge clk) begin
      if (!reset_n) begin
         cmd_stall = 1'b0;
         dat_stall = 1'b0;
      end else begin
         if (cmd_stall) begin
            check("cmd_hold_valid", 256'(m_axis_cmd_tvalid), 256'd1);
            check("cmd_hold_data", 256'(m_axis_cmd_tdata), 256'(cmd_prev));
         end
         if (dat_stall) begin
            check("dat_hold_valid", 256'(m_axis_tvalid), 256'd1);
            check("dat_hold_data", 256'({m_axis_tlast, m_axis_tdata}), 256'(dat_prev));
         end
         cmd_stall = m_axis_cmd_tvalid && !m_axis_cmd_tready;
         cmd_prev  = m_axis_cmd_tdata;
         dat_stall = m_axis_tvalid && !m_axis_tready;
         dat_prev  = {m_axis_tlast, m_axis_tdata};
         if (m_axis_cmd_tvalid && m_axis_cmd_tready) begin
            check("cmd_expected", 256'(cmd_q.size() > 0), 256'd1);
            if (cmd_q.size() > 0) check("cmd_word", 256'(m_axis_cmd_tdata), 256'(cmd_q.pop_front()));
         end
         if (m_axis_tvalid && m_axis_tready) begin
            check("beat_expected", 256'(beat_q.size() > 0), 256'd1);
            if (beat_q.size() > 0)
               check("beat_last_data", 256'({m_axis_tlast, m_axis_tdata}), 256'(beat_q.pop_front()));
            check("beat_keep", 256'(m_axis_tkeep), 256'hF);
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_rdy) m_axis_tready = 1'($urandom_range(0, 1));
      end
   end

   initial begin
      int n;
      logic [31:0] exp_err;

      reset_n           = 1'b0;
      start             = 1'b0;
      stop              = 1'b0;
      m_axis_cmd_tready = 1'b1;
      m_axis_tready     = 1'b1;
      s_axis_sts_tdata  = 8'h00;
      s_axis_sts_tvalid = 1'b0;
      #2;
      check_all_zero("reset_outputs");
      tick();
      tick();
      reset_n = 1'b1;
      tick();
      check("sts_tready_after_reset", 256'(s_axis_sts_tready), 256'd1);
      check("tkeep_after_reset", 256'(m_axis_tkeep), 256'hF);
      check("busy_idle", 256'(busy), 256'd0);

      // Three bursts through a two-buffer ring: addrs 0x0, 0x10, 0x0, tags 0..2.
      for (int i = 0; i < 3; i++) expect_burst();
      check("first_cmd_model", 256'(cmd_q[0]), 256'h00_00000000_40800010);
      pulse_start(1'b0);
      check("busy_after_start", 256'(busy), 256'd1);
      n = 0;
      while (burst_count != 32'd2 && n < BUDGET) begin
         tick();
         n++;
      end
      check("ring_wait", 256'(n < BUDGET), 256'd1);
      check("no_bubble_cmd", 256'(m_axis_cmd_tvalid), 256'd1);
      pulse_stop();
      wait_idle("ring_idle_wait");
      check("ring_burst_count", 256'(burst_count), 256'(m_bursts));
      check("ring_queues_drained", 256'(cmd_q.size() + beat_q.size()), 256'd0);

      // Command backpressure then randomised data backpressure across two bursts.
      m_axis_cmd_tready = 1'b0;
      expect_burst();
      expect_burst();
      pulse_start(1'b0);
      for (int i = 0; i < 10; i++) begin
         check("cmd_valid_while_blocked", 256'(m_axis_cmd_tvalid), 256'd1);
         tick();
      end
      m_axis_cmd_tready = 1'b1;
      rand_rdy          = 1'b1;
      n = 0;
      while (burst_count != m_bursts - 32'd1 && n < BUDGET) begin
         tick();
         n++;
      end
      check("stall_wait", 256'(n < BUDGET), 256'd1);
      pulse_stop();
      wait_idle("stall_idle_wait");
      rand_rdy      = 1'b0;
      m_axis_tready = 1'b1;
      check("stall_burst_count", 256'(burst_count), 256'(m_bursts));
      check("stall_queues_drained", 256'(cmd_q.size() + beat_q.size()), 256'd0);

      // Stop during beat 2: burst completes, busy falls one cycle after tlast.
      expect_burst();
      pulse_start(1'b0);
      n = 0;
      while (!m_axis_tvalid && n < BUDGET) begin
         tick();
         n++;
      end
      check("stop_data_wait", 256'(n < BUDGET), 256'd1);
      tick();
      pulse_stop();
      n = 0;
      while (!(m_axis_tvalid && m_axis_tlast) && n < BUDGET) begin
         tick();
         n++;
      end
      check("stop_last_wait", 256'(n < BUDGET), 256'd1);
      check("stop_busy_at_last", 256'(busy), 256'd1);
      tick();
      check("stop_busy_fall", 256'(busy), 256'd0);
      check("stop_burst_count", 256'(burst_count), 256'(m_bursts));
      for (int i = 0; i < 10; i++) begin
         check("stop_no_cmd", 256'(m_axis_cmd_tvalid), 256'd0);
         tick();
      end

      // Status words 0x80 (tag ok), 0x85 (tag mismatch), 0x02 (OKAY clear).
      s_axis_sts_tvalid = 1'b1;
      s_axis_sts_tdata  = 8'h80;
      tick();
      s_axis_sts_tdata  = 8'h85;
      tick();
      s_axis_sts_tdata  = 8'h02;
      tick();
      s_axis_sts_tvalid = 1'b0;
      tick();
`ifdef S2MM_STS_CHECK_EN
      exp_err = 32'd2;
`else
      exp_err = 32'd0;
`endif
      check("sts_count", 256'(sts_count), 256'd3);
      check("last_sts", 256'(last_sts), 256'h02);
      check("err_count", 256'(err_count), 256'(exp_err));

      // Asynchronous reset in the middle of a burst.
      expect_burst();
      pulse_start(1'b0);
      n = 0;
      while (!m_axis_tvalid && n < BUDGET) begin
         tick();
         n++;
      end
      check("areset_data_wait", 256'(n < BUDGET), 256'd1);
      tick();
      #2;
      reset_n = 1'b0;
      #1;
      check_all_zero("areset_outputs");
      cmd_q.delete();
      beat_q.delete();
      m_addr   = BASE;
      m_tag    = 4'h0;
      m_pat    = '1;
      m_ring   = 0;
      m_bursts = 0;
      tick();
      tick();
      reset_n = 1'b1;
      tick();

      // Start and stop together: exactly one burst from BASE_ADDR, tag 0, pattern all ones.
      expect_burst();
      pulse_start(1'b1);
      wait_idle("restart_idle_wait");
      check("restart_burst_count", 256'(burst_count), 256'd1);
      check("restart_queues_drained", 256'(cmd_q.size() + beat_q.size()), 256'd0);
      repeat (4) tick();
      check("restart_no_cmd", 256'(m_axis_cmd_tvalid), 256'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
